cacheline_burst_adapter: RTL and testbench
==========================================

# cacheline_burst_adapter

Converts 256-bit cache-line transactions from the cache datapath, whose 32-bit CPU-side words are already packed and unpacked by the line bus adapter, into 4-beat × 64-bit bursts on the physical-memory port, and back.
- Sits directly downstream of the cache's 256-bit line interface.
- Services exactly one outstanding line read or line write at a time.
- Raises a single-cycle response to the cache when the whole line has moved.

## Interface
Parameters: none (line 256 bits, beat 64 bits, 4 beats fixed).
Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- line_i  in  256  write-back line from cache
- line_o  out  256  assembled fill line to cache
- address_i  in  32  cache line address
- read_i  in  1  cache requests line fill
- write_i  in  1  cache requests line write-back
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  64  memory read beat
- burst_o  out  64  memory write beat
- address_o  out  32  memory burst address, {addr[31:5], 5'b0}
- read_o  out  1  memory burst read request
- write_o  out  1  memory burst write request
- resp_i  in  1  memory beat strobe; one beat per cycle high

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples read_i/write_i.
  - write_i high → WRITE; else read_i high → READ. Write wins if both are high.
  - On accept, latch address_i with bits [4:0] forced to 0, latch line_i on a write, and clear the beat counter to 0.
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1.
  - Each cycle resp_i=1: line_o[64*k +: 64] ← burst_i, k ← k+1.
  - Beat 0 goes into the least significant bits.
  - After beat 3 is captured → DONE.
  - Cycles with resp_i=0 are stalls; beats need not be contiguous.
- WRITE:
  - write_o=1, burst_o = latched_line[64*k +: 64] combinationally from the counter.
  - Each cycle resp_i=1 advances k.
  - After beat 3 is accepted → DONE.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0 → IDLE.
- The cache must drop read_i/write_i in the cycle after resp_o. Requests are only sampled in IDLE, so a request held high re-triggers from IDLE.
- The beat counter is 2 bits. It wraps 3→0 on the final beat and is never observed at 4.
- line_o holds the last completed fill until the next fill writes it. A write-back never modifies line_o.
- address_o holds the latched address through the whole transaction and DONE. It is unchanged in IDLE.

## Timing
- Reset (rst sampled high): state IDLE, counter 0, resp_o=0, read_o=0, write_o=0, address_o=0, line_o=0, latched line=0, burst_o=0.
- Reset mid-burst aborts immediately:
  - Next cycle read_o/write_o=0 and no resp_o.
  - line_o is cleared even if beats were partially captured.
- Request sampled at cycle T → read_o/write_o high from T+1.
- Final beat (resp_i=1, k=3) at cycle B:
  - resp_o=1 at B+1, with line_o fully valid in the same cycle for reads.
  - read_o/write_o=0 at B+1.
  - IDLE at B+2.
- Minimum read latency with back-to-back beats: request T, beats T+1..T+4, resp_o T+5, next request accepted T+6.
- burst_o is valid whenever write_o=1. Outside WRITE it shows beat 0 of the latched line.
- No combinational path from resp_i to resp_o.

## Test plan
- Read, contiguous beats:
  - Stimulus: read_i with address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - Required: address_o=0x0000_1220; line_o={0x44..44, 0x33..33, 0x22..22, 0x11..11}; one resp_o pulse 1 cycle after the last beat.
- Write, stalled beats:
  - Stimulus: line_i=256'h0123…CDEF; resp_i pattern 1,0,0,1,1,0,1.
  - Required: burst_o steps through line_i[63:0], [127:64], [191:128], [255:192] only on resp_i cycles; resp_o exactly once; line_o unchanged.
- Simultaneous requests:
  - Stimulus: read_i=write_i=1 in IDLE.
  - Required: only write_o asserted, read_o stays 0 throughout.
- Reset mid-read:
  - Stimulus: rst after 2 beats.
  - Required: next cycle read_o=0, line_o=0, no resp_o. A following read completes normally with a fresh 4 beats.
- Back-to-back:
  - Stimulus: read, then write, with the cache dropping its request after resp_o.
  - Required: the second request is accepted the cycle after DONE; no stray resp_i in IDLE advances anything.
- Spurious resp_i in IDLE:
  - Stimulus: 3 resp_i pulses with no request, then a read.
  - Required: the read still captures exactly 4 beats starting at beat 0.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// Bridges a 256-bit cache line port onto a 4-beat x 64-bit physical-memory burst port.
// One line transfer at a time; resp_o pulses once when the whole line has moved.
module cacheline_burst_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1F);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             beat_q;
  logic [BEATS-1:0][BEAT_W-1:0] fill_q;
  logic [BEATS-1:0][BEAT_W-1:0] wb_q;
  logic                         accept;
  logic                         beat_xfer;

  assign accept    = (state_q == IDLE) && (read_i || write_i);
  assign beat_xfer = ((state_q == READ) || (state_q == WRITE)) && resp_i;

  // Next-state: write wins over read; last beat moves to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (write_i)     state_d = WRITE;
        else if (read_i) state_d = READ;
      end
      READ, WRITE: begin
        if (resp_i && (beat_q == CNT_W'(BEATS - 1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Registered handshake outputs and line/beat datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
      address_o <= '0;
      beat_q    <= '0;
      fill_q    <= '0;
      wb_q      <= '0;
    end else begin
      read_o  <= (state_d == READ);
      write_o <= (state_d == WRITE);
      resp_o  <= (state_d == DONE);
      if (accept) begin
        address_o <= address_i & LINE_MASK;
        beat_q    <= '0;
        if (write_i) wb_q <= line_i;
      end
      if ((state_q == READ) && resp_i) fill_q[beat_q] <= burst_i;
      // Counter wraps 3->0 on the final beat, leaving it ready for the next line.
      if (beat_xfer) beat_q <= beat_q + CNT_W'(1);
    end
  end

  assign line_o  = fill_q;
  assign burst_o = (state_q == WRITE) ? wb_q[beat_q] : wb_q[0];

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Scenario bench for cacheline_burst_adapter: expected lines and write beats are
// queued when stimulus is driven and popped when the adapter produces them.
module tb_cacheline_burst_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_cmp;
  int unsigned  n_err;
  logic [255:0] rd_q[$];
  logic [63:0]  wr_q[$];
  logic [255:0] last_fill;
  logic [255:0] exp_line;
  logic [63:0]  exp_beat;
  logic [31:0]  last_addr;

  function automatic logic [63:0] rep64(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a read and returns on the cycle the DONE state is visible.
  task automatic drive_read(input logic [31:0] addr, input logic [255:0] line);
    read_i    = 1'b1;
    address_i = addr;
    tick();
    read_i = 1'b0;
    rd_q.push_back(line);
    for (int k = 0; k < 4; k++) begin
      resp_i  = 1'b1;
      burst_i = line[k*64 +: 64];
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; line_i = '1; address_i = '1; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({resp_o, read_o, write_o, address_o, line_o, burst_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got resp=%0b rd=%0b wr=%0b addr=%h burst=%h line=%h want all zero",
               resp_o, read_o, write_o, address_o, burst_o, line_o);
    end
    rst = 1'b0; line_i = '0; address_i = '0;
    tick();
    n_cmp++;
    if ({resp_o, read_o, write_o} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset got resp/rd/wr=%b want 000", {resp_o, read_o, write_o});
    end
  endtask

  task automatic test_read_contig();
    logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    read_i = 1'b0;
    n_cmp++;
    if ({read_o, write_o} !== 2'b10) begin
      n_err++; $display("FAIL read_req rd/wr got %b want 10", {read_o, write_o});
    end
    n_cmp++;
    if (address_o !== 32'h0000_1220) begin
      n_err++; $display("FAIL read_addr got %h want 00001220", address_o);
    end
    rd_q.push_back({rep64(8'h44), rep64(8'h33), rep64(8'h22), rep64(8'h11)});
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1; burst_i = rep64(pat[k]);
      tick();
      if (k < 3) begin
        n_cmp++;
        if ({resp_o, read_o} !== 2'b01) begin
          n_err++; $display("FAIL read_beat%0d resp/rd got %b want 01", k, {resp_o, read_o});
        end
      end
    end
    resp_i = 1'b0; burst_i = '0;
    n_cmp++;
    if ({resp_o, read_o} !== 2'b10) begin
      n_err++; $display("FAIL read_done resp/rd got %b want 10", {resp_o, read_o});
    end
    exp_line = rd_q.pop_front();
    n_cmp++;
    if (line_o !== exp_line) begin
      n_err++; $display("FAIL read_line got %h want %h", line_o, exp_line);
    end
    last_fill = exp_line;
    tick();
    n_cmp++;
    if (resp_o !== 1'b0 || address_o !== 32'h0000_1220) begin
      n_err++; $display("FAIL read_after resp=%0b addr=%h want 0 00001220", resp_o, address_o);
    end
  endtask

  task automatic test_write_stall();
    logic [255:0] wline;
    logic [0:6]   pat;
    wline = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    pat   = 7'b1001101;
    line_i = wline; write_i = 1'b1; address_i = 32'h8000_003F;
    tick();
    write_i = 1'b0; line_i = '0;
    n_cmp++;
    if ({read_o, write_o} !== 2'b01 || address_o !== 32'h8000_0020) begin
      n_err++; $display("FAIL write_req rd/wr=%b addr=%h want 01 80000020", {read_o, write_o}, address_o);
    end
    for (int k = 0; k < 4; k++) wr_q.push_back(wline[k*64 +: 64]);
    for (int i = 0; i < 7; i++) begin
      exp_beat = wr_q[0];
      n_cmp++;
      if (burst_o !== exp_beat || {resp_o, write_o} !== 2'b01) begin
        n_err++; $display("FAIL write_cycle%0d burst=%h resp/wr=%b want %h 01", i, burst_o, {resp_o, write_o}, exp_beat);
      end
      resp_i = pat[i];
      if (pat[i]) void'(wr_q.pop_front());
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if ({resp_o, write_o} !== 2'b10) begin
      n_err++; $display("FAIL write_done resp/wr got %b want 10", {resp_o, write_o});
    end
    n_cmp++;
    if (line_o !== last_fill) begin
      n_err++; $display("FAIL write_keeps_line got %h want %h", line_o, last_fill);
    end
    tick();
    n_cmp++;
    if (resp_o !== 1'b0 || burst_o !== wline[63:0]) begin
      n_err++; $display("FAIL write_after resp=%0b burst=%h want 0 %h", resp_o, burst_o, wline[63:0]);
    end
  endtask

  task automatic test_simultaneous();
    line_i = {4{rep64(8'h5A)}}; read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040;
    tick();
    read_i = 1'b0; write_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({read_o, write_o} !== 2'b01) begin
        n_err++; $display("FAIL both_req cycle%0d rd/wr got %b want 01", k, {read_o, write_o});
      end
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if ({resp_o, read_o, write_o} !== 3'b100 || line_o !== last_fill) begin
      n_err++; $display("FAIL both_done resp/rd/wr=%b line=%h want 100 %h", {resp_o, read_o, write_o}, line_o, last_fill);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] fresh;
    int unsigned  pulses;
    fresh = {rep64(8'hD4), rep64(8'hC3), rep64(8'hB2), rep64(8'hA1)};
    read_i = 1'b1; address_i = 32'h0000_0100;
    tick();
    read_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = rep64(8'hEE);
      tick();
    end
    resp_i = 1'b0; burst_i = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({resp_o, read_o} !== 2'b00 || line_o !== '0) begin
      n_err++; $display("FAIL rst_abort resp/rd=%b line=%h want 00 zero", {resp_o, read_o}, line_o);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++; $display("FAIL rst_no_resp got %0d pulses want 0", pulses);
    end
    drive_read(32'h0000_0140, fresh);
    exp_line = rd_q.pop_front();
    n_cmp++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      n_err++; $display("FAIL rst_refill resp=%0b line=%h want 1 %h", resp_o, line_o, exp_line);
    end
    last_fill = exp_line;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] rline;
    logic [255:0] wline;
    rline = {rep64(8'h08), rep64(8'h07), rep64(8'h06), rep64(8'h05)};
    wline = {rep64(8'hF4), rep64(8'hF3), rep64(8'hF2), rep64(8'hF1)};
    drive_read(32'h0000_2000, rline);
    exp_line = rd_q.pop_front();
    n_cmp++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      n_err++; $display("FAIL b2b_read resp=%0b line=%h want 1 %h", resp_o, line_o, exp_line);
    end
    last_fill = exp_line;
    resp_i = 1'b1;
    tick();
    n_cmp++;
    if ({resp_o, read_o, write_o} !== 3'b000) begin
      n_err++; $display("FAIL b2b_idle resp/rd/wr got %b want 000", {resp_o, read_o, write_o});
    end
    write_i = 1'b1; line_i = wline; address_i = 32'h0000_3004;
    tick();
    write_i = 1'b0; resp_i = 1'b0; line_i = '0;
    for (int k = 0; k < 4; k++) wr_q.push_back(wline[k*64 +: 64]);
    n_cmp++;
    if (write_o !== 1'b1 || address_o !== 32'h0000_3000) begin
      n_err++; $display("FAIL b2b_accept wr=%0b addr=%h want 1 00003000", write_o, address_o);
    end
    for (int k = 0; k < 4; k++) begin
      exp_beat = wr_q.pop_front();
      n_cmp++;
      if (burst_o !== exp_beat) begin
        n_err++; $display("FAIL b2b_beat%0d burst got %h want %h", k, burst_o, exp_beat);
      end
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    n_cmp++;
    if ({resp_o, write_o} !== 2'b10) begin
      n_err++; $display("FAIL b2b_write_done resp/wr got %b want 10", {resp_o, write_o});
    end
    last_addr = 32'h0000_3000;
    tick();
  endtask

  task automatic test_spurious_resp();
    logic [255:0] line;
    line = {rep64(8'h9D), rep64(8'h9C), rep64(8'h9B), rep64(8'h9A)};
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1; burst_i = rep64(8'hBD);
      tick();
      resp_i = 1'b0; burst_i = '0;
      n_cmp++;
      if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== last_addr) begin
        n_err++; $display("FAIL spur_idle%0d resp/rd/wr=%b addr=%h want 000 %h", i, {resp_o, read_o, write_o}, address_o, last_addr);
      end
      tick();
    end
    drive_read(32'h0000_4020, line);
    exp_line = rd_q.pop_front();
    n_cmp++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      n_err++; $display("FAIL spur_read resp=%0b line=%h want 1 %h", resp_o, line_o, exp_line);
    end
    tick();
    n_cmp++;
    if (resp_o !== 1'b0 || line_o !== exp_line) begin
      n_err++; $display("FAIL spur_hold resp=%0b line=%h want 0 %h", resp_o, line_o, exp_line);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_fill = '0;
    last_addr = '0;
    test_reset();
    test_read_contig();
    test_write_stall();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    test_spurious_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached at %0t want bench finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
